// File: rtl/memory_controller.sv
// Initiator for the 8x8 memory array: one request at a time, sequenced as SETUP/ACCESS/HOLD on the array bus.
// Optional power-on clear of every row is enabled by defining MEM_CLEAR_EN.
module memory_controller #(
    parameter int ACCESS_CYCLES = 1,
    parameter int ADDR_W        = 3,
    parameter int DATA_W        = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_address,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              mem_op,
    output logic              mem_select,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_input,
    input  logic [DATA_W-1:0] mem_data_output,
    output logic [2:0]        dbg_state
);

    // Handshakes: a request transfers on a rising edge where req_valid && req_ready;
    // a response transfers on a rising edge where rsp_valid && rsp_ready. A source
    // holds its payload stable until the transfer edge.

`ifdef MEM_CLEAR_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        HOLD   = 3'd3,
        RESP   = 3'd4,
        CLEAR  = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        ACCESS = 3'd2,
        HOLD   = 3'd3,
        RESP   = 3'd4
    } state_t;
`endif

    state_t      state;
    logic [3:0]  cnt;
`ifdef MEM_CLEAR_EN
    logic [ADDR_W-1:0] row;
    logic              clearing;
`endif

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
`ifdef MEM_CLEAR_EN
            state    <= CLEAR;
            row      <= '0;
            clearing <= 1'b1;
`else
            state    <= IDLE;
`endif
            cnt            <= '0;
            req_ready      <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
            busy           <= 1'b0;
            mem_op         <= 1'b0;
            mem_select     <= 1'b0;
            mem_address    <= '0;
            mem_data_input <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        mem_op         <= req_write;
                        mem_address    <= req_address;
                        mem_data_input <= req_wdata;
                        req_ready      <= 1'b0;
                        busy           <= 1'b1;
                        state          <= SETUP;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                SETUP: begin
                    mem_select <= 1'b1;
                    cnt        <= 4'(ACCESS_CYCLES - 1);
                    state      <= ACCESS;
                end
                ACCESS: begin
                    if (cnt == 4'd0) begin
                        // The array read path is combinational, so data is valid on this last edge.
                        mem_select <= 1'b0;
                        rsp_data   <= mem_op ? '0 : mem_data_output;
                        state      <= HOLD;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                HOLD: begin
`ifdef MEM_CLEAR_EN
                    if (clearing) begin
                        if (&row) begin
                            clearing  <= 1'b0;
                            busy      <= 1'b0;
                            req_ready <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            row   <= row + ADDR_W'(1);
                            state <= CLEAR;
                        end
                    end else begin
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end
`else
                    rsp_valid <= 1'b1;
                    state     <= RESP;
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
`ifdef MEM_CLEAR_EN
                CLEAR: begin
                    mem_op         <= 1'b1;
                    mem_address    <= row;
                    mem_data_input <= '0;
                    busy           <= 1'b1;
                    state          <= SETUP;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_controller.sv
// Bench for memory_controller: table of single transactions plus directed stall, reset and clear sequences.
// Two instances: ACCESS_CYCLES=1 (main) and ACCESS_CYCLES=4.
module tb_memory_controller;

    logic       clk, reset, preload;
    logic       req_valid, req_ready, req_write, rsp_valid, rsp_ready, busy;
    logic       mem_op, mem_select;
    logic [2:0] req_address, mem_address, dbg_state;
    logic [7:0] req_wdata, rsp_data, mem_data_input, mem_data_output;

    logic       r4_valid, r4_ready, r4_write, r4_rsp_valid, r4_rsp_ready, r4_busy;
    logic       r4_mem_op, r4_mem_select;
    logic [2:0] r4_address, r4_mem_address, r4_dbg_state;
    logic [7:0] r4_wdata, r4_rsp_data, r4_mem_data_input, r4_mem_data_output;

    logic [7:0] mem [8];
    logic [7:0] mem4 [8];

`ifdef MEM_CLEAR_EN
    localparam logic [7:0] PRE = 8'h00;
`else
    localparam logic [7:0] PRE = 8'hFF;
`endif
    localparam int LIMIT = 200;

    int checks = 0;
    int errors = 0;
    int sel_total = 0;
    int stab_viol = 0;
    logic prev_sel = 1'b0;
    logic [2:0] prev_addr;
    logic [7:0] prev_din;
    logic [2:0] wr_rows[$];

    memory_controller #(.ACCESS_CYCLES(1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_address(req_address), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy), .mem_op(mem_op), .mem_select(mem_select),
        .mem_address(mem_address), .mem_data_input(mem_data_input),
        .mem_data_output(mem_data_output), .dbg_state(dbg_state)
    );

    memory_controller #(.ACCESS_CYCLES(4)) dut4 (
        .clk(clk), .reset(reset),
        .req_valid(r4_valid), .req_ready(r4_ready), .req_write(r4_write),
        .req_address(r4_address), .req_wdata(r4_wdata),
        .rsp_valid(r4_rsp_valid), .rsp_ready(r4_rsp_ready), .rsp_data(r4_rsp_data),
        .busy(r4_busy), .mem_op(r4_mem_op), .mem_select(r4_mem_select),
        .mem_address(r4_mem_address), .mem_data_input(r4_mem_data_input),
        .mem_data_output(r4_mem_data_output), .dbg_state(r4_dbg_state)
    );

    // Clock and array models
    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_data_output    = mem[mem_address];
    assign r4_mem_data_output = mem4[r4_mem_address];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 8; i++) begin
                mem[i]  <= 8'hFF;
                mem4[i] <= 8'hFF;
            end
        end else begin
            if (mem_select && mem_op) mem[mem_address] <= mem_data_input;
            if (r4_mem_select && r4_mem_op) mem4[r4_mem_address] <= r4_mem_data_input;
        end
    end

    // Bus monitor for the main instance
    always @(negedge clk) begin
        if (mem_select) begin
            sel_total <= sel_total + 1;
            if (prev_sel && (mem_address !== prev_addr || mem_data_input !== prev_din))
                stab_viol <= stab_viol + 1;
            if (!prev_sel && mem_op) wr_rows.push_back(mem_address);
        end
        prev_sel  <= mem_select;
        prev_addr <= mem_address;
        prev_din  <= mem_data_input;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!req_ready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(n < LIMIT), 32'd1);
    endtask

    // Single transaction on the main instance with rsp_ready held high.
    task automatic do_txn(input logic w, input logic [2:0] a, input logic [7:0] d,
                          output logic [7:0] data, output int lat, output int sels);
        int s0;
        @(negedge clk);
        wait_ready("req_ready_timeout");
        s0 = sel_total;
        req_valid = 1'b1; req_write = w; req_address = a; req_wdata = d;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < LIMIT) begin
            @(posedge clk); #1;
            lat++;
        end
        data = rsp_data;
        @(posedge clk); #1;
        @(negedge clk);
        sels = sel_total - s0;
    endtask

    typedef struct {
        logic       w;
        logic [2:0] a;
        logic [7:0] d;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[9];

    initial begin
        logic [7:0] data;
        int lat, sels, n, s0, rv;

        vecs[0] = '{1'b1, 3'd3, 8'hA5, 8'h00};
        vecs[1] = '{1'b0, 3'd3, 8'h00, 8'hA5};
        vecs[2] = '{1'b1, 3'd0, 8'h3C, 8'h00};
        vecs[3] = '{1'b1, 3'd7, 8'hC3, 8'h00};
        vecs[4] = '{1'b0, 3'd0, 8'h00, 8'h3C};
        vecs[5] = '{1'b0, 3'd7, 8'h00, 8'hC3};
        vecs[6] = '{1'b1, 3'd3, 8'h5A, 8'h00};
        vecs[7] = '{1'b0, 3'd3, 8'h00, 8'h5A};
        vecs[8] = '{1'b0, 3'd5, 8'h00, PRE};

        reset = 1'b1; preload = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_address = '0; req_wdata = '0; rsp_ready = 1'b1;
        r4_valid = 1'b0; r4_write = 1'b0; r4_address = '0; r4_wdata = '0; r4_rsp_ready = 1'b1;

        // Reset held for two edges
        @(negedge clk); preload = 1'b0;
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_data", 32'(rsp_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_mem_op", 32'(mem_op), 0);
        check("rst_mem_select", 32'(mem_select), 0);
        check("rst_mem_address", 32'(mem_address), 0);
        check("rst_mem_data_input", 32'(mem_data_input), 0);
        reset = 1'b0;
        @(negedge clk);
`ifdef MEM_CLEAR_EN
        check("post_rst_req_ready", 32'(req_ready), 0);
        check("post_rst_busy", 32'(busy), 1);
        wait_ready("clear_timeout");
        check("clear_rsp_valid", 32'(rsp_valid), 0);
        check("clear_pulses", 32'(wr_rows.size()), 8);
        for (int i = 0; i < 8 && i < wr_rows.size(); i++)
            check($sformatf("clear_row_order_%0d", i), 32'(wr_rows[i]), 32'(i));
        for (int i = 0; i < 8; i++)
            check($sformatf("clear_mem_%0d", i), 32'(mem[i]), 0);
`else
        check("post_rst_req_ready", 32'(req_ready), 1);
        check("post_rst_busy", 32'(busy), 0);
`endif

        // Table-driven single transactions
        for (int i = 0; i < 9; i++) begin
            do_txn(vecs[i].w, vecs[i].a, vecs[i].d, data, lat, sels);
            check($sformatf("vec%0d_rsp_data", i), 32'(data), 32'(vecs[i].exp));
            check($sformatf("vec%0d_latency", i), 32'(lat), 3);
            check($sformatf("vec%0d_select_cycles", i), 32'(sels), 1);
        end
        check("mem3_after_writes", 32'(mem[3]), 32'h5A);

        // Long access: ACCESS_CYCLES=4, read row 7
        @(negedge clk);
        n = 0;
        while (!r4_ready && n < LIMIT) begin @(negedge clk); n++; end
        check("r4_ready_timeout", 32'(n < LIMIT), 1);
        r4_valid = 1'b1; r4_write = 1'b0; r4_address = 3'd7;
        @(posedge clk); #1;
        r4_valid = 1'b0;
        lat = 0; sels = 0; n = 0;
        while (!r4_rsp_valid && lat < LIMIT) begin
            if (r4_mem_address !== 3'd7 || r4_mem_op !== 1'b0) n++;
            @(posedge clk); #1;
            lat++;
            if (r4_mem_select) sels++;
        end
        check("ac4_latency", 32'(lat), 6);
        check("ac4_select_cycles", 32'(sels), 4);
        check("ac4_bus_stable", 32'(n), 0);
        check("ac4_rsp_data", 32'(r4_rsp_data), 32'(PRE));

        // Response stall with competing request pulses
        @(negedge clk);
        wait_ready("stall_req_ready_timeout");
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_address = 3'd3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < LIMIT) begin @(negedge clk); n++; end
        check("stall_rsp_timeout", 32'(n < LIMIT), 1);
        s0 = sel_total;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("stall_rsp_valid_%0d", i), 32'(rsp_valid), 1);
            check($sformatf("stall_rsp_data_%0d", i), 32'(rsp_data), 32'h5A);
            check($sformatf("stall_req_ready_%0d", i), 32'(req_ready), 0);
            req_valid = (i % 2 == 1); req_write = 1'b1; req_address = 3'd0; req_wdata = 8'hEE;
        end
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("stall_rsp_taken", 32'(rsp_valid), 0);
        check("stall_no_access", 32'(sel_total - s0), 0);
        check("stall_mem0_kept", 32'(mem[0]), 32'h3C);

        // Reset in the middle of ACCESS
        @(negedge clk);
        wait_ready("rstmid_req_ready_timeout");
        req_valid = 1'b1; req_write = 1'b0; req_address = 3'd7;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("rstmid_select_before", 32'(mem_select), 1);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        check("rstmid_select_after", 32'(mem_select), 0);
        check("rstmid_rsp_valid", 32'(rsp_valid), 0);
        @(negedge clk); reset = 1'b0;
        rv = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid) rv++;
        end
        check("rstmid_no_response", 32'(rv), 0);
`ifdef MEM_CLEAR_EN
        do_txn(1'b0, 3'd7, 8'h00, data, lat, sels);
        check("rstmid_next_rsp_data", 32'(data), 32'h00);
`else
        do_txn(1'b0, 3'd7, 8'h00, data, lat, sels);
        check("rstmid_next_rsp_data", 32'(data), 32'hC3);
`endif
        check("rstmid_next_latency", 32'(lat), 3);
        check("rstmid_next_select_cycles", 32'(sels), 1);

        check("bus_stable_under_select", 32'(stab_viol), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
